mem_arbiter: RTL and testbench

- Shares the single byte-wide unified RAM port between instruction fetch (IF) and the MEM stage.
- Sequences each 32-bit access as four little-endian byte beats.
- Raises a stall request to ctrl while any access is pending.
- Sits between pc_reg/if_id and mem on one side, and the external RAM on the other. It replaces the direct rom_*/ram_* connections of the CPU top.

---
 rtl/mem_arbiter_pkg.sv | 48 ++++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-RAM arbiter: FSM states, byte bus type,
// beat count, requester identifiers and byte-lane helpers.
package mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One byte on the RAM data bus
    typedef logic [7:0] byte_bus_t;

    // Bytes per word access
    localparam int NUM_BEATS = 4;

    // Requester identifiers latched at grant time
    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    // Extract little-endian byte lane k from a word
    function automatic byte_bus_t get_byte(input logic [31:0] word, input logic [1:0] k);
        byte_bus_t b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Replace little-endian byte lane k of a word
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] k,
                                             input byte_bus_t b);
        logic [31:0] w;
        w = word;
        case (k)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide synchronous RAM port between instruction
// fetch and the MEM stage. Each 32-bit access is four little-endian byte
// beats; reads take one extra DRAIN cycle to collect the last byte, which
// arrives one cycle after its address. MEM wins ties; a requester whose
// done pulse is high this cycle is not re-granted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BEATS  = NUM_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction fetch side
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    // MEM stage side
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic [3:0]        mem_byte_selected_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_done_o,
    // External RAM port
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_we_o,
    input  logic [7:0]        ram_data_i,
    // Pipeline control
    output logic              stall_req_o
);

    // The beat counter and byte-lane helpers are two bits wide
    if (BEATS != 4) begin : g_beats_check
        $error("mem_arbiter supports only BEATS == 4");
    end

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_e            state_q,    state_d;
    logic [1:0]        beat_q,     beat_d;
    logic              req_id_q,   req_id_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic              we_q,       we_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [3:0]        sel_q,      sel_d;
    logic [31:0]       data_q,     data_d;
    logic [31:0]       if_data_q,  if_data_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              if_done_q,  if_done_d;
    logic              mem_done_q, mem_done_d;

    logic              xfer_done;
    logic [1:0]        cap_idx;
    logic              mem_eligible;
    logic              if_eligible;

    // A requester is eligible only while its own done pulse is low
    assign mem_eligible = mem_req_i & ~mem_done_q;
    assign if_eligible  = if_req_i  & ~if_done_q;

    // Lane of the byte returned this cycle: RAM answers one beat late
    assign cap_idx = beat_q - 2'd1;

    // Next-state: arbitration, beat sequencing, byte assembly, completion
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        req_id_d   = req_id_q;
        base_d     = base_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        data_d     = data_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;
        xfer_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                beat_d = 2'd0;
                if (mem_eligible) begin
                    state_d  = ST_BEAT;
                    req_id_d = REQ_MEM;
                    base_d   = mem_addr_i;
                    we_d     = mem_we_i;
                    wdata_d  = mem_data_i;
                    sel_d    = mem_byte_selected_i;
                    data_d   = 32'd0;
                end else if (if_eligible) begin
                    state_d  = ST_BEAT;
                    req_id_d = REQ_IF;
                    base_d   = if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = 32'd0;
                    sel_d    = 4'd0;
                    data_d   = 32'd0;
                end
            end

            ST_BEAT: begin
                // Collect the byte addressed in the previous beat
                if (!we_q && beat_q != 2'd0) begin
                    data_d = put_byte(data_q, cap_idx, ram_data_i);
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d = 2'd0;
                    if (we_q) begin
                        state_d   = ST_IDLE;
                        xfer_done = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end

            ST_DRAIN: begin
                // Last byte of a read arrives here
                data_d    = put_byte(data_q, LAST_BEAT, ram_data_i);
                state_d   = ST_IDLE;
                beat_d    = 2'd0;
                xfer_done = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                beat_d  = 2'd0;
            end
        endcase

        // Pulse the owner's done and publish read data on its port
        if (xfer_done) begin
            if (req_id_q == REQ_MEM) begin
                mem_done_d = 1'b1;
                if (!we_q) begin
                    mem_data_d = data_d;
                end
            end else begin
                if_done_d = 1'b1;
                if_data_d = data_d;
            end
        end
    end

    // RAM port drive: active only during beats, parked at zero otherwise
    always_comb begin
        ram_addr_o = '0;
        ram_data_o = 8'd0;
        ram_we_o   = 1'b0;
        if (state_q == ST_BEAT) begin
            ram_addr_o = base_q + {{(ADDR_W-2){1'b0}}, beat_q};
            if (we_q) begin
                ram_data_o = get_byte(wdata_q, beat_q);
                ram_we_o   = sel_q[beat_q];
            end
        end
    end

    // State registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= 2'd0;
            req_id_q   <= REQ_IF;
            base_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            sel_q      <= 4'd0;
            data_q     <= 32'd0;
            if_data_q  <= 32'd0;
            mem_data_q <= 32'd0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            req_id_q   <= req_id_d;
            base_q     <= base_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    assign if_data_o   = if_data_q;
    assign if_done_o   = if_done_q;
    assign mem_data_o  = mem_data_q;
    assign mem_done_o  = mem_done_q;

    // Stall drops in the same cycle as the matching done pulse
    assign stall_req_o = mem_eligible | if_eligible;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;

    // Write log of the RAM model, indexed by low 12 address bits
    bit [7:0] wmem [0:4095];
    bit       wvld [0:4095];

    mem_arbiter #(.ADDR_W(32), .BEATS(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_req_i            (if_req),
        .if_addr_i           (if_addr),
        .if_data_o           (if_data),
        .if_done_o           (if_done),
        .mem_req_i           (mem_req),
        .mem_we_i            (mem_we),
        .mem_addr_i          (mem_addr),
        .mem_data_i          (mem_wdata),
        .mem_byte_selected_i (mem_sel),
        .mem_data_o          (mem_rdata),
        .mem_done_o          (mem_done),
        .ram_addr_o          (ram_addr),
        .ram_data_o          (ram_wdata),
        .ram_we_o            (ram_we),
        .ram_data_i          (ram_rdata),
        .stall_req_o         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed initial RAM image
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h05;
            32'h0000_0102: return 8'h10;
            32'h0000_0103: return 8'h00;
            32'h0000_0104: return 8'hAA;
            32'h0000_0105: return 8'hBB;
            32'h0000_0106: return 8'hCC;
            32'h0000_0107: return 8'hDD;
            32'h0000_0200: return 8'h11;
            32'h0000_0201: return 8'h22;
            32'h0000_0202: return 8'h33;
            32'h0000_0203: return 8'h44;
            32'h0000_0300: return 8'h01;
            32'h0000_0301: return 8'h02;
            32'h0000_0302: return 8'h03;
            32'h0000_0303: return 8'h04;
            32'hFFFF_FFFE: return 8'h11;
            32'hFFFF_FFFF: return 8'h22;
            32'h0000_0000: return 8'h33;
            32'h0000_0001: return 8'h44;
            default:       return 8'h00;
        endcase
    endfunction

    // Synchronous RAM: read data one cycle after address, writes logged
    always @(posedge clk) begin
        ram_rdata <= wvld[ram_addr[11:0]] ? wmem[ram_addr[11:0]] : rom_byte(ram_addr);
        if (ram_we) begin
            wmem[ram_addr[11:0]] <= ram_wdata;
            wvld[ram_addr[11:0]] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge (start of a new cycle)
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    logic [31:0] exp_addr [4];
    logic        exp_we   [4];
    int          pulses;

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_sel   = 4'd0;

        // Reset state
        @(negedge clk);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_data", {24'd0, ram_wdata}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_mem_done", {31'd0, mem_done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_data", mem_rdata, 32'd0);
        next_cycle();
        rst = 1'b1;
        skip(2);

        // IF read at 0x100
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        check("if_stall_c0", {31'd0, stall}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("if_addr_c%0d", k + 1), ram_addr, 32'h100 + k);
            check($sformatf("if_stall_c%0d", k + 1), {31'd0, stall}, 32'd1);
            check($sformatf("if_we_c%0d", k + 1), {31'd0, ram_we}, 32'd0);
        end
        next_cycle();
        @(negedge clk);
        check("if_done_c5", {31'd0, if_done}, 32'd0);
        check("if_stall_c5", {31'd0, stall}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("if_done_c6", {31'd0, if_done}, 32'd1);
        check("if_data_c6", if_data, 32'h0010_0513);
        check("if_stall_c6", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("if_done_c7", {31'd0, if_done}, 32'd0);
        check("if_idle_addr", ram_addr, 32'd0);

        // MEM write 0xDEADBEEF, sel 0011, at 0x200
        next_cycle();
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h200;
        mem_wdata = 32'hDEAD_BEEF;
        mem_sel   = 4'b0011;
        exp_we    = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("wr_addr_c%0d", k + 1), ram_addr, 32'h200 + k);
            check($sformatf("wr_we_c%0d", k + 1), {31'd0, ram_we}, {31'd0, exp_we[k]});
            check($sformatf("wr_done_c%0d", k + 1), {31'd0, mem_done}, 32'd0);
            if (k == 0) check("wr_data_c1", {24'd0, ram_wdata}, 32'hEF);
            if (k == 1) check("wr_data_c2", {24'd0, ram_wdata}, 32'hBE);
        end
        next_cycle();
        @(negedge clk);
        check("wr_done_c5", {31'd0, mem_done}, 32'd1);
        check("wr_stall_c5", {31'd0, stall}, 32'd0);
        check("wr_mem_data_held", mem_rdata, 32'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        next_cycle();
        @(negedge clk);
        check("wr_done_c6", {31'd0, mem_done}, 32'd0);
        check("wr_byte_200", {24'd0, wmem[12'h200]}, 32'hEF);
        check("wr_byte_201", {24'd0, wmem[12'h201]}, 32'hBE);
        check("wr_untouched_202", {31'd0, wvld[12'h202]}, 32'd0);
        check("wr_untouched_203", {31'd0, wvld[12'h203]}, 32'd0);

        // Simultaneous requests: MEM read at 0x300, IF at 0x104
        next_cycle();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h300;
        mem_sel  = 4'b0000;
        if_req   = 1'b1;
        if_addr  = 32'h104;
        next_cycle();
        @(negedge clk);
        check("both_mem_first", ram_addr, 32'h300);
        skip(5);
        @(negedge clk);
        check("both_mem_done_c6", {31'd0, mem_done}, 32'd1);
        check("both_mem_data", mem_rdata, 32'h0403_0201);
        check("both_if_waits", {31'd0, if_done}, 32'd0);
        check("both_stall_c6", {31'd0, stall}, 32'd1);
        mem_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("both_if_addr_c7", ram_addr, 32'h104);
        check("both_mem_done_c7", {31'd0, mem_done}, 32'd0);
        skip(4);
        @(negedge clk);
        check("both_if_done_c11", {31'd0, if_done}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("both_if_done_c12", {31'd0, if_done}, 32'd1);
        check("both_if_data", if_data, 32'hDDCC_BBAA);
        check("both_mem_data_held", mem_rdata, 32'h0403_0201);
        if_req = 1'b0;

        // Address wrap: MEM read at 0xFFFFFFFE
        next_cycle();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'hFFFF_FFFE;
        exp_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("wrap_addr_c%0d", k + 1), ram_addr, exp_addr[k]);
        end
        skip(2);
        @(negedge clk);
        check("wrap_done_c6", {31'd0, mem_done}, 32'd1);
        check("wrap_data", mem_rdata, 32'h4433_2211);
        mem_req = 1'b0;
        next_cycle();

        // Reset during cycle 3 of a write
        next_cycle();
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h400;
        mem_wdata = 32'h1234_5678;
        mem_sel   = 4'b1111;
        skip(3);
        @(negedge clk);
        check("rstw_we_before", {31'd0, ram_we}, 32'd1);
        check("rstw_addr_before", ram_addr, 32'h402);
        #1;
        rst = 1'b0;
        #1;
        check("rstw_we_now", {31'd0, ram_we}, 32'd0);
        check("rstw_addr_now", ram_addr, 32'd0);
        check("rstw_mem_data", mem_rdata, 32'd0);
        check("rstw_if_data", if_data, 32'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        next_cycle();
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            if (mem_done || ram_we) pulses++;
        end
        check("rstw_no_done", pulses, 32'd0);
        check("rstw_wrote_401", {31'd0, wvld[12'h401]}, 32'd1);
        check("rstw_not_402", {31'd0, wvld[12'h402]}, 32'd0);
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h100;
        next_cycle();
        @(negedge clk);
        check("rstw_if_addr_c1", ram_addr, 32'h100);
        skip(5);
        @(negedge clk);
        check("rstw_if_done_c6", {31'd0, if_done}, 32'd1);
        check("rstw_if_data", if_data, 32'h0010_0513);

        // IF request held across done, address moves to 0x104
        if_addr = 32'h104;
        check("held_stall_done", {31'd0, stall}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("held_no_regrant", ram_addr, 32'd0);
        check("held_stall_c7", {31'd0, stall}, 32'd1);
        check("held_done_c7", {31'd0, if_done}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("held_addr_c8", ram_addr, 32'h104);
        skip(5);
        @(negedge clk);
        check("held_done_c13", {31'd0, if_done}, 32'd1);
        check("held_data", if_data, 32'hDDCC_BBAA);
        if_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("held_done_c14", {31'd0, if_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
